// File: rtl/div_gen.sv
// Fully pipelined signed divider: sign/magnitude stage, DATA_W restoring stages,
// sign-correction stage and output register. One operation per clock, fixed latency.
module div_gen #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = DATA_W + 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_dividend_tvalid,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata,
  output logic                  m_axis_dout_tvalid
);

  if (LATENCY != DATA_W + 2) begin : g_bad_latency
    $error("div_gen: LATENCY must equal DATA_W+2");
  end

  // Index 0 is the sign/magnitude stage, 1..DATA_W are the restoring stages.
  logic              vld_d  [0:DATA_W];
  logic              vld_q  [0:DATA_W];
  logic [DATA_W-1:0] num_d  [0:DATA_W];
  logic [DATA_W-1:0] num_q  [0:DATA_W];
  logic [DATA_W-1:0] quo_d  [0:DATA_W];
  logic [DATA_W-1:0] quo_q  [0:DATA_W];
  logic [DATA_W-1:0] rem_d  [0:DATA_W];
  logic [DATA_W-1:0] rem_q  [0:DATA_W];
  logic [DATA_W:0]   den_d  [0:DATA_W];
  logic [DATA_W:0]   den_q  [0:DATA_W];
  logic              qneg_d [0:DATA_W];
  logic              qneg_q [0:DATA_W];
  logic              rneg_d [0:DATA_W];
  logic              rneg_q [0:DATA_W];
  logic              dz_d   [0:DATA_W];
  logic              dz_q   [0:DATA_W];

  logic                sc_vld_d, sc_vld_q;
  logic [2*DATA_W-1:0] sc_data_d, sc_data_q;
  logic                out_vld_q;
  logic [2*DATA_W-1:0] out_data_d, out_data_q;

  logic              a_neg, b_neg;
  logic [DATA_W:0]   b_ext;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] q_fix, r_fix;

  always_comb begin
    a_neg = s_axis_dividend_tdata[DATA_W-1];
    b_neg = s_axis_divisor_tdata[DATA_W-1];
    b_ext = {b_neg, s_axis_divisor_tdata};

    // An unsigned reading of the DATA_W-bit negation is the exact magnitude, even for -2^(W-1).
    vld_d[0]  = s_axis_dividend_tvalid & s_axis_divisor_tvalid;
    num_d[0]  = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    quo_d[0]  = '0;
    rem_d[0]  = '0;
    den_d[0]  = b_neg ? -b_ext : b_ext;
    qneg_d[0] = a_neg ^ b_neg;
    rneg_d[0] = a_neg;
    dz_d[0]   = (s_axis_divisor_tdata == '0);

    trial = '0;
    for (int s = 1; s <= DATA_W; s++) begin
      trial     = {rem_q[s-1], num_q[s-1][DATA_W-1]};
      vld_d[s]  = vld_q[s-1];
      num_d[s]  = num_q[s-1] << 1;
      den_d[s]  = den_q[s-1];
      qneg_d[s] = qneg_q[s-1];
      rneg_d[s] = rneg_q[s-1];
      dz_d[s]   = dz_q[s-1];
      if (trial >= den_q[s-1]) begin
        rem_d[s] = DATA_W'(trial - den_q[s-1]);
        quo_d[s] = {quo_q[s-1][DATA_W-2:0], 1'b1};
      end else begin
        rem_d[s] = DATA_W'(trial);
        quo_d[s] = {quo_q[s-1][DATA_W-2:0], 1'b0};
      end
    end

    q_fix = qneg_q[DATA_W] ? -quo_q[DATA_W] : quo_q[DATA_W];
    if (dz_q[DATA_W]) q_fix = '1;
    r_fix = rneg_q[DATA_W] ? -rem_q[DATA_W] : rem_q[DATA_W];

    sc_vld_d   = vld_q[DATA_W];
    sc_data_d  = {q_fix, r_fix};
    out_data_d = sc_vld_q ? sc_data_q : out_data_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int s = 0; s <= DATA_W; s++) begin
        vld_q[s]  <= 1'b0;
        num_q[s]  <= '0;
        quo_q[s]  <= '0;
        rem_q[s]  <= '0;
        den_q[s]  <= '0;
        qneg_q[s] <= 1'b0;
        rneg_q[s] <= 1'b0;
        dz_q[s]   <= 1'b0;
      end
      sc_vld_q   <= 1'b0;
      sc_data_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      for (int s = 0; s <= DATA_W; s++) begin
        vld_q[s]  <= vld_d[s];
        num_q[s]  <= num_d[s];
        quo_q[s]  <= quo_d[s];
        rem_q[s]  <= rem_d[s];
        den_q[s]  <= den_d[s];
        qneg_q[s] <= qneg_d[s];
        rneg_q[s] <= rneg_d[s];
        dz_q[s]   <= dz_d[s];
      end
      sc_vld_q   <= sc_vld_d;
      sc_data_q  <= sc_data_d;
      out_vld_q  <= sc_vld_q;
      out_data_q <= out_data_d;
    end
  end

  assign m_axis_dout_tvalid = out_vld_q;
  assign m_axis_dout_tdata  = out_data_q;

endmodule

// File: tb/tb_div_gen.sv
// Directed and reference-checked bench for div_gen: result values, latency, ordering,
// tdata hold, divide-by-zero, single-channel valid and mid-flight reset.
module tb_div_gen;

  localparam int unsigned DATA_W  = 8;
  localparam int          LAT     = 10;

  logic                aclk;
  logic                areset;
  logic [DATA_W-1:0]   dividend, divisor;
  logic                dividend_vld, divisor_vld;
  logic [2*DATA_W-1:0] dout;
  logic                dout_vld;

  div_gen #(.DATA_W(DATA_W), .LATENCY(LAT)) dut (
    .aclk                  (aclk),
    .areset                (areset),
    .s_axis_dividend_tdata (dividend),
    .s_axis_dividend_tvalid(dividend_vld),
    .s_axis_divisor_tdata  (divisor),
    .s_axis_divisor_tvalid (divisor_vld),
    .m_axis_dout_tdata     (dout),
    .m_axis_dout_tvalid    (dout_vld)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pulse = 0;
  int          n_exp = 0;
  logic [15:0] last_data = '0;

  always @(posedge aclk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    int sa, sd, q, r;
    sa = int'($signed(a));
    sd = int'($signed(b));
    if (sd == 0) return {8'hFF, a};
    q = sa / sd;
    r = sa % sd;
    return {q[7:0], r[7:0]};
  endfunction

  // Drive one accepted operation for one cycle; valids are left high for back-to-back use.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    exp_t e;
    dividend     = a;
    divisor      = b;
    dividend_vld = 1'b1;
    divisor_vld  = 1'b1;
    e.d = exp;
    e.c = cyc + 1;
    sb.push_back(e);
    n_exp++;
    @(negedge aclk);
  endtask

  task automatic idle(input int n);
    dividend_vld = 1'b0;
    divisor_vld  = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  // Output monitor, sampling just after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      #1;
      if (areset) begin
        check_eq("rst_tvalid", {31'd0, dout_vld}, 32'd0);
        check_eq("rst_tdata", {16'd0, dout}, 32'd0);
        last_data = '0;
      end else if (dout_vld) begin
        n_pulse++;
        if (sb.size() == 0) begin
          check_eq("spurious_pulse", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("dout", {16'd0, dout}, {16'd0, e.d});
          check_eq("latency", cyc - e.c, LAT);
        end
        last_data = dout;
      end else begin
        check_eq("tdata_hold", {16'd0, dout}, {16'd0, last_data});
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    areset       = 1'b1;
    dividend     = '0;
    divisor      = '0;
    dividend_vld = 1'b0;
    divisor_vld  = 1'b0;
    #100;
    @(negedge aclk);
    areset = 1'b0;
    idle(5);

    send(8'd1, 8'd1, 16'h0100); idle(1);
    send(8'd1, 8'd2, 16'h0001); idle(1);
    send(8'd1, 8'd3, 16'h0001); idle(12);
    check_eq("first_three_pulses", n_pulse, 3);

    send(8'hF8, 8'h08, 16'hFF00); idle(1);
    send(8'h07, 8'hFE, 16'hFD01); idle(1);
    send(8'hF9, 8'h02, 16'hFDFF); idle(1);
    send(8'h80, 8'hFF, 16'h8000); idle(1);
    send(8'h7F, 8'h01, 16'h7F00); idle(1);
    send(8'h05, 8'h00, 16'hFF05); idle(1);
    send(8'hFD, 8'h00, 16'hFFFD); idle(1);
    send(8'h64, 8'h07, 16'h0E02); idle(1);

    // Dividend valid alone must be ignored.
    dividend     = 8'h11;
    divisor      = 8'h03;
    dividend_vld = 1'b1;
    divisor_vld  = 1'b0;
    repeat (3) @(negedge aclk);
    idle(14);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(ra, rb, ref_div(ra, rb));
    end
    idle(14);
    check_eq("drained_random", sb.size(), 0);

    send(8'd9, 8'd2, 16'h0401);
    send(8'd10, 8'd3, 16'h0301);
    send(8'hF6, 8'd4, 16'hFEFE);
    send(8'd50, 8'd5, 16'h0A00);
    idle(5);
    areset = 1'b1;
    n_exp -= sb.size();
    sb.delete();
    idle(3);
    areset = 1'b0;
    idle(2);
    send(8'd100, 8'd7, 16'h0E02);
    idle(15);

    check_eq("drained_final", sb.size(), 0);
    check_eq("pulse_count", n_pulse, n_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_gen.md
Name: div_gen

Overview:
Fully pipelined signed integer divider with AXI4-Stream-style inputs and output: separate dividend and divisor channels, one result channel. It accepts one operation per clock and returns quotient and remainder after a fixed latency. It is a non-blocking block with no tready on any channel, and it is used by the color-detect datapath for per-pixel ratio computation.

Parameters:
DATA_W, 8, operand width in bits; result width is 2*DATA_W.
LATENCY, DATA_W+2 (10), cycles from input acceptance to m_axis_dout_tvalid; fixed, not runtime-variable.

Ports:
aclk  in  1  clock; all logic is rising-edge.
areset  in  1  asynchronous active-high reset; clears the pipeline.
s_axis_dividend_tdata  in  DATA_W  dividend, two's complement.
s_axis_dividend_tvalid  in  1  dividend valid.
s_axis_divisor_tdata  in  DATA_W  divisor, two's complement.
s_axis_divisor_tvalid  in  1  divisor valid.
m_axis_dout_tdata  out  2*DATA_W  {quotient[DATA_W-1:0], remainder[DATA_W-1:0]}.
m_axis_dout_tvalid  out  1  result valid, single-cycle pulse per operation.

Behaviour:
- Reset: areset high asynchronously clears all stage valid bits, m_axis_dout_tvalid=0 and m_axis_dout_tdata=0. Both stay 0 while areset is high.
- Reset mid-operation: all in-flight operations are discarded and no result is ever emitted for them.
- Acceptance: an operation issues on a rising edge where both s_axis_dividend_tvalid and s_axis_divisor_tvalid are 1.
  - If only one tvalid is high, that cycle is ignored; nothing is buffered and nothing is emitted.
- Throughput: one operation per cycle; back-to-back accepts are allowed.
- Latency: an operation accepted at edge N produces m_axis_dout_tvalid=1 for exactly one cycle, registered at edge N+LATENCY, with the matching tdata.
  - Results emerge in issue order.
  - The output has no backpressure.
- tdata hold: when tvalid=0, tdata holds its last value. It is don't-care to consumers but must be deterministic.
- Arithmetic: signed truncating division (round toward zero).
  - quotient = trunc(dividend/divisor); remainder = dividend - quotient*divisor.
  - The remainder sign equals the dividend sign, or it is 0.
- Structure:
  - Stage 0 registers the sign of each operand and converts both operands to magnitudes (DATA_W+1 bits internally, so -128 is representable).
  - DATA_W restoring-division stages follow, one quotient bit per stage.
  - A final stage applies sign correction: quotient negated if the operand signs differ; remainder negated if the dividend is negative.
  - The result is registered to the output.
- Overflow: most-negative / -1 (-128/-1) yields quotient 0x80 (wraps), remainder 0x00.
- Divide by zero: quotient = all-ones (0xFF), remainder = dividend unchanged, tvalid asserted normally. No error flag.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Hold areset=1 for 100 ns, then release. Check m_axis_dout_tvalid=0 and tdata=0x0000 throughout; sending no tvalid must produce no output pulse.
- Drive dividend=1/divisor=1, then 1/2, then 1/3, each with both tvalids high for one cycle and a 1-cycle gap. Expect exactly three tvalid pulses, each 10 cycles after its accept, with tdata 0x0100, 0x0001 and 0x0001 in order.
- Drive -8/8 (0xF8, 0x08) -> 0xFF00. Drive 7/-2 -> 0xFD01. Drive -7/2 -> 0xFDFF. Drive -128/-1 -> 0x8000. Drive 127/1 -> 0x7F00.
- Drive 5/0 -> 0xFF05 and -3/0 -> 0xFFFD, each with a normal tvalid pulse. Drive dividend tvalid alone for 3 cycles -> no output pulse.
- Drive random signed operands on every cycle for 200 cycles. Results must match a reference model in order, with tvalid continuously high from cycle 10 onward.
- Issue 4 operations, then assert areset 5 cycles later. Expect no tvalid pulse for those 4 operations; a new operation after release returns correctly at LATENCY.
